serial_add_sequencer: RTL and testbench

- Bit-serial multi-bit adder controller that reuses one full_adder cell (A, B, Cin -> Sum, Carry) for every bit position.
- Captures two WIDTH-bit operands and a carry-in on a start request, then feeds one bit pair per clock, LSB first, into the cell.
- Holds the ripple carry in a flop and assembles the sum; presents the registered result with a one-cycle done pulse.
- Sits between a requesting datapath and the shared full_adder cell, trading latency for area.

---
 rtl/serial_add_sequencer_if.sv | 24 ++
 rtl/serial_add_sequencer.sv | 107 ++++++++++
 tb/tb_serial_add_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/serial_add_sequencer_if.sv
// Request/result bundle between a datapath and the bit-serial adder sequencer.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] Data_in_A;
  logic [WIDTH-1:0] Data_in_B;
  logic             Data_in_C;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Data_out_Sum;
  logic             Data_out_Carry;
  logic             Data_out_Ovf;

  modport master (
    output start, Data_in_A, Data_in_B, Data_in_C,
    input  busy, done, Data_out_Sum, Data_out_Carry, Data_out_Ovf
  );

  modport slave (
    input  start, Data_in_A, Data_in_B, Data_in_C,
    output busy, done, Data_out_Sum, Data_out_Carry, Data_out_Ovf
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: one full-adder cell reused per bit, LSB first, with a
// registered result and a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit pair through the cell per clock (WIDTH cycles)
// DONE  | result valid, done high; start here begins the next add
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_add_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q, ovf_q;

  logic             load_op, last_bit;
  logic             cell_sum, cell_carry;
  logic [WIDTH-1:0] sum_next;

  // The shared full-adder cell
  always_comb begin
    cell_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    cell_carry = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
    sum_next   = (sum_sr_q >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_op  = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_op = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_BIT) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load_op = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (load_op) begin
      a_sr_q  <= bus.Data_in_A;
      b_sr_q  <= bus.Data_in_B;
      carry_q <= bus.Data_in_C;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sr_q   <= a_sr_q >> 1;
      b_sr_q   <= b_sr_q >> 1;
      sum_sr_q <= sum_next;
      carry_q  <= cell_carry;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last_bit) begin
        // carry_q still holds the carry into the MSB on this edge
        sum_q       <= sum_next;
        carry_out_q <= cell_carry;
        ovf_q       <= carry_q ^ cell_carry;
      end
    end
  end

  assign bus.busy           = (state_q == RUN);
  assign bus.done           = (state_q == DONE);
  assign bus.Data_out_Sum   = sum_q;
  assign bus.Data_out_Carry = carry_out_q;
  assign bus.Data_out_Ovf   = ovf_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer at WIDTH=1 and WIDTH=8.
module tb_serial_add_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_add_sequencer_if #(.WIDTH(1)) bus1 ();
  serial_add_sequencer_if #(.WIDTH(8)) bus8 ();

  serial_add_sequencer #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  serial_add_sequencer #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge after start is edge 1; returns the edge count at which done is seen.
  task automatic wait_done8(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    tick();
    bus8.start = 1'b0;
    while (!bus8.done && lat < 40) begin
      if (bus8.busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus8.Data_in_A = a;
    bus8.Data_in_B = b;
    bus8.Data_in_C = c;
    bus8.start     = 1'b1;
  endtask

  initial begin
    int lat;
    int busy_n;
    logic [7:0] fa_sum_tbl;
    logic [7:0] fa_carry_tbl;
    logic [2:0] abc;

    fa_sum_tbl   = 8'b1001_0110;
    fa_carry_tbl = 8'b1110_1000;

    bus1.start = 1'b0; bus1.Data_in_A = '0; bus1.Data_in_B = '0; bus1.Data_in_C = 1'b0;
    bus8.start = 1'b0; bus8.Data_in_A = '0; bus8.Data_in_B = '0; bus8.Data_in_C = 1'b0;
    tick();
    tick();
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_sum", bus8.Data_out_Sum, 0);
    check("rst_carry", bus8.Data_out_Carry, 0);
    check("rst_ovf", bus8.Data_out_Ovf, 0);
    rst_n = 1'b1;
    tick();

    // WIDTH=1: full-adder truth table, done two edges after start
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      bus1.Data_in_A = abc[2];
      bus1.Data_in_B = abc[1];
      bus1.Data_in_C = abc[0];
      bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      check("w1_busy", bus1.busy, 1);
      check("w1_done_early", bus1.done, 0);
      tick();
      check("w1_done", bus1.done, 1);
      check("w1_sum", bus1.Data_out_Sum, fa_sum_tbl[abc]);
      check("w1_carry", bus1.Data_out_Carry, fa_carry_tbl[abc]);
      check("w1_ovf", bus1.Data_out_Ovf, abc[0] ^ fa_carry_tbl[abc]);
      tick();
      check("w1_idle", bus1.done, 0);
    end

    // 0xFF + 0x01
    drive8(8'hFF, 8'h01, 1'b0);
    wait_done8(lat, busy_n);
    check("ff01_lat", lat, 9);
    check("ff01_busy_cycles", busy_n, 8);
    check("ff01_sum", bus8.Data_out_Sum, 8'h00);
    check("ff01_carry", bus8.Data_out_Carry, 1);
    check("ff01_ovf", bus8.Data_out_Ovf, 0);
    tick();
    check("ff01_done_pulse", bus8.done, 0);
    check("ff01_hold", bus8.Data_out_Sum, 8'h00);

    // 0x7F + 0x01 signed overflow
    drive8(8'h7F, 8'h01, 1'b0);
    wait_done8(lat, busy_n);
    check("7f01_lat", lat, 9);
    check("7f01_sum", bus8.Data_out_Sum, 8'h80);
    check("7f01_carry", bus8.Data_out_Carry, 0);
    check("7f01_ovf", bus8.Data_out_Ovf, 1);
    tick();

    // 0xA5 + 0x5A + 1, with a start re-pulse mid-RUN that must be ignored
    drive8(8'hA5, 8'h5A, 1'b1);
    tick();
    bus8.start = 1'b0;
    lat = 1;
    repeat (3) begin tick(); lat++; end
    bus8.Data_in_A = 8'h01;
    bus8.Data_in_B = 8'h00;
    bus8.Data_in_C = 1'b0;
    bus8.start = 1'b1;
    tick();
    lat++;
    bus8.start = 1'b0;
    bus8.Data_in_A = 8'hFF;
    while (!bus8.done && lat < 40) begin tick(); lat++; end
    check("a55a_lat", lat, 9);
    check("a55a_sum", bus8.Data_out_Sum, 8'h00);
    check("a55a_carry", bus8.Data_out_Carry, 1);
    check("a55a_ovf", bus8.Data_out_Ovf, 0);

    // Back-to-back start in the DONE cycle
    drive8(8'h03, 8'h04, 1'b0);
    wait_done8(lat, busy_n);
    check("b2b_lat", lat, 9);
    check("b2b_busy_cycles", busy_n, 8);
    check("b2b_sum", bus8.Data_out_Sum, 8'h07);
    check("b2b_carry", bus8.Data_out_Carry, 0);
    tick();

    // Reset four cycles into RUN aborts the add
    drive8(8'hFF, 8'hFF, 1'b1);
    tick();
    bus8.start = 1'b0;
    repeat (4) tick();
    check("abort_busy_before", bus8.busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus8.busy, 0);
    check("abort_done", bus8.done, 0);
    check("abort_sum", bus8.Data_out_Sum, 8'h00);
    busy_n = 0;
    repeat (2) begin tick(); if (bus8.done) busy_n++; end
    rst_n = 1'b1;
    repeat (10) begin tick(); if (bus8.done) busy_n++; end
    check("abort_no_done", busy_n, 0);
    check("abort_sum_held", bus8.Data_out_Sum, 8'h00);

    drive8(8'h10, 8'h20, 1'b0);
    wait_done8(lat, busy_n);
    check("post_rst_lat", lat, 9);
    check("post_rst_sum", bus8.Data_out_Sum, 8'h30);
    check("post_rst_carry", bus8.Data_out_Carry, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
